bram_debug_loader: RTL

Synthesizable host-side controller for the core's two debug BRAM ports (DataRAM and InstRAM port 2). It accepts a byte command stream (typically from a UART receiver), writes words into either BRAM, streams BRAM contents back out as bytes, and holds the core in reset while memory is being accessed. It replaces the load/dump sequence used in simulation with hardware that runs on the board beside the RV32 core.

---
 rtl/bram_debug_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bram_debug_loader.sv
// bram_debug_loader: byte-stream host controller that loads and dumps the core's debug BRAM ports
module bram_debug_loader #(
    parameter int BRAMWORDS = 4096
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] CPU_Debug_DataRAM_A2,
    output logic [31:0] CPU_Debug_DataRAM_WD2,
    output logic [3:0]  CPU_Debug_DataRAM_WE2,
    input  logic [31:0] CPU_Debug_DataRAM_RD2,
    output logic [31:0] CPU_Debug_InstRAM_A2,
    output logic [31:0] CPU_Debug_InstRAM_WD2,
    output logic [3:0]  CPU_Debug_InstRAM_WE2,
    input  logic [31:0] CPU_Debug_InstRAM_RD2,
    output logic        core_rst,
    output logic        busy
);
    localparam int IDX_W = $clog2(BRAMWORDS);

    typedef enum logic [2:0] {IDLE, HDR, WR_COLLECT, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND} state_t;

    state_t             state, nstate;
    logic               tgt, is_rd, rx_fire, cmd_ok, last, we;
    logic [1:0]         op, hcnt, bcnt;
    logic [IDX_W-9:0]   sh;
    logic [IDX_W-1:0]   idx, n_idx;
    logic [IDX_W:0]     left;
    logic [23:0]        word;
    logic [31:0]        rd_word, a2_q, wd_q, a2, idx_addr;

    assign op       = rx_data[2:1];
    assign rx_fire  = rx_valid && rx_ready;
    assign cmd_ok   = rx_data[7:3] == 5'd0 && op != 2'b00;
    assign last     = left == (IDX_W+1)'(1);
    assign n_idx    = {sh, rx_data};
    assign idx_addr = {{(30-IDX_W){1'b0}}, idx, 2'b00};

    // state register
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) state <= IDLE;
        else state <= nstate;
    end

    // next-state: header then either the write collect/commit loop or the read address/wait/send loop
    always_comb begin
        nstate = state;
        case (state)
            IDLE:       nstate = (rx_fire && cmd_ok && op != 2'b11) ? HDR : IDLE;
            HDR:        nstate = (rx_fire && hcnt == 2'd3) ? (is_rd ? RD_ADDR : WR_COLLECT) : HDR;
            WR_COLLECT: nstate = (rx_fire && bcnt == 2'd3) ? WR_COMMIT : WR_COLLECT;
            WR_COMMIT:  nstate = last ? IDLE : WR_COLLECT;
            RD_ADDR:    nstate = RD_WAIT;
            RD_WAIT:    nstate = RD_SEND;
            RD_SEND:    nstate = (tx_ready && bcnt == 2'd3) ? (last ? IDLE : RD_ADDR) : RD_SEND;
            default:    nstate = IDLE;
        endcase
    end

    // outputs: handshakes from state, the untargeted BRAM port is parked at zero
    always_comb begin
        rx_ready = !CPU_RST && (state == IDLE || state == HDR || state == WR_COLLECT);
        busy     = state != IDLE;
        tx_valid = state == RD_SEND;
        tx_data  = tx_valid ? rd_word[31:24] : 8'h00;
        we       = state == WR_COMMIT;
        a2       = state == RD_ADDR ? idx_addr : a2_q;
        CPU_Debug_DataRAM_A2  = tgt ? 32'd0 : a2;
        CPU_Debug_DataRAM_WD2 = tgt ? 32'd0 : wd_q;
        CPU_Debug_DataRAM_WE2 = (!tgt && we) ? 4'hF : 4'h0;
        CPU_Debug_InstRAM_A2  = tgt ? a2 : 32'd0;
        CPU_Debug_InstRAM_WD2 = tgt ? wd_q : 32'd0;
        CPU_Debug_InstRAM_WE2 = (tgt && we) ? 4'hF : 4'h0;
    end

    // datapath: command decode, header capture, word assembly, index/count stepping, read shift-out
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            tgt      <= 1'b0;
            is_rd    <= 1'b0;
            hcnt     <= 2'd0;
            bcnt     <= 2'd0;
            sh       <= '0;
            idx      <= '0;
            left     <= '0;
            word     <= 24'd0;
            rd_word  <= 32'd0;
            a2_q     <= 32'd0;
            wd_q     <= 32'd0;
            core_rst <= 1'b1;
        end else begin
            case (state)
                IDLE: if (rx_fire && cmd_ok) begin
                    tgt      <= rx_data[0];
                    is_rd    <= op == 2'b10;
                    core_rst <= op != 2'b11;
                    hcnt     <= 2'd0;
                end
                HDR: if (rx_fire) begin
                    hcnt <= hcnt + 2'd1;
                    sh   <= rx_data[IDX_W-9:0];
                    bcnt <= 2'd0;
                    if (hcnt == 2'd1) idx <= n_idx;
                    if (hcnt == 2'd3) left <= {~|n_idx, n_idx};
                end
                WR_COLLECT: if (rx_fire) begin
                    word <= {word[15:0], rx_data};
                    bcnt <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        a2_q <= idx_addr;
                        wd_q <= {word, rx_data};
                    end
                end
                WR_COMMIT: begin
                    idx  <= idx + 1'b1;
                    left <= left - 1'b1;
                end
                RD_ADDR: a2_q <= idx_addr;
                RD_WAIT: begin
                    rd_word <= tgt ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
                    bcnt    <= 2'd0;
                end
                RD_SEND: if (tx_ready) begin
                    rd_word <= rd_word << 8;
                    bcnt    <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        idx  <= idx + 1'b1;
                        left <= left - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
